// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD up/down counters: digit limit, run state and
// the preset clamp used when loading digits.
package bcd_pkg;

   localparam logic [3:0] BCD_MAX = 4'd9;

   typedef enum logic {IDLE, RUN} state_t;

   function automatic logic [3:0] clamp_bcd(input logic [3:0] nib);
      return (nib > BCD_MAX) ? BCD_MAX : nib;
   endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One loadable BCD digit that steps down by one when enabled, wrapping 0 -> 9.
module bcd_digit_down
   import bcd_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       ld,
   input  logic [3:0] ld_digit,
   input  logic       en,
   output logic [3:0] digit,
   output logic       is_zero
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         digit <= 4'd0;
      end else if (ld) begin
         digit <= clamp_bcd(ld_digit);
      end else if (en) begin
         digit <= (digit == 4'd0) ? BCD_MAX : digit - 4'd1;
      end
   end

   assign is_zero = (digit == 4'd0);

endmodule

// File: rtl/bcd_down_timer.sv
// Loadable N-digit BCD countdown timer with run/hold control, per-digit borrow
// enables and a one-cycle done pulse on reaching zero.
module bcd_down_timer
   import bcd_pkg::*;
#(
   parameter int N_DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [4*N_DIGITS-1:0] load_val,
   input  logic                  start,
   input  logic                  hold,
   output logic [4*N_DIGITS-1:0] q,
   output logic [N_DIGITS-1:1]   ena,
   output logic                  busy,
   output logic                  done
);

   state_t              state;
   logic [N_DIGITS-1:0] is_zero;
   logic [N_DIGITS-1:0] zero_below;
   logic [N_DIGITS-1:0] en;
   logic                dec;
   logic                last;
   logic                q_zero;

   assign busy = (state == RUN);
   assign dec  = busy & ~hold;

   // Digit k steps only when every lower digit is already zero.
   assign zero_below[0] = 1'b1;
   for (genvar k = 1; k < N_DIGITS; k++) begin : g_chain
      assign zero_below[k] = zero_below[k-1] & is_zero[k-1];
   end

   assign en  = {N_DIGITS{dec}} & zero_below;
   assign ena = en[N_DIGITS-1:1];

   for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
      bcd_digit_down u_digit (
         .clk      (clk),
         .reset    (reset),
         .ld       (load),
         .ld_digit (load_val[4*k +: 4]),
         .en       (en[k]),
         .digit    (q[4*k +: 4]),
         .is_zero  (is_zero[k])
      );
   end

   assign q_zero = &is_zero;
   // This decrement lands on zero: only digit 0 is non-zero and it holds 1.
   assign last   = dec & (q[3:0] == 4'd1) & (&is_zero[N_DIGITS-1:1]);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         done  <= 1'b0;
      end else if (load) begin
         state <= IDLE;
         done  <= 1'b0;
      end else if (start && state == IDLE && !q_zero) begin
         state <= RUN;
         done  <= 1'b0;
      end else if (last) begin
         state <= IDLE;
         done  <= 1'b1;
      end else begin
         done  <= 1'b0;
      end
   end

endmodule

// File: doc/bcd_down_timer.md
# bcd_down_timer

Loadable 4-digit BCD countdown timer, the down-counting counterpart of the team's 4-digit BCD up counter. It is used for user-visible countdowns such as stopwatch and alarm-style timers. The block decrements one BCD count per enabled clock, exposes per-digit borrow enables, and signals completion with a busy level and a one-cycle done pulse. Its output format is identical to the up counter, so both feed the same 7-segment/display path.

## Interface
- N_DIGITS, 4, number of BCD digits; q width is 4*N_DIGITS, ena width is N_DIGITS-1 (indices [N_DIGITS-1:1])
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- load  in  1  load load_val into q, abort any run
- load_val  in  16  BCD preset value, digit 0 in [3:0]
- start  in  1  begin countdown from current q
- hold  in  1  pause decrement while running
- q  out  16  current BCD count (registered)
- ena  out  3  ena[k] high when digit k decrements at the next edge
- busy  out  1  high while state is RUN
- done  out  1  one-cycle pulse when a run reaches 0000

## Operation
- States: IDLE, RUN.
- Reset drives q=0x0000, state=IDLE, busy=0, done=0, ena=0.
- Priority at each edge is: load, then start, then decrement.
- **Load:**
  - Valid in any state.
  - q <= load_val with each nibble >9 clamped to 9 (e.g. 0x00AF -> 0x0099).
  - State goes to IDLE, and done=0 in the following cycle.
- **Start:**
  - In IDLE with q≠0, state goes to RUN and q is unchanged at that edge.
  - Start in IDLE with q=0 is ignored: no busy, no done.
  - Start in RUN is ignored.
- **Decrement:**
  - Each edge with state=RUN and hold=0, q <= q−1 in BCD.
  - Digit 0 always steps; a digit at 0 wraps to 9 and borrows.
  - Digit k steps only when digits 0..k−1 are all 0.
- **ena (combinational):**
  - ena[k] = busy & ~hold & (digits 0..k−1 all zero).
  - ena[1] therefore = busy & ~hold & (q[3:0]==0).
- **Terminal count:**
  - The decrement edge that produces q=0x0000 also moves state to IDLE.
  - That edge registers done=1 for exactly one cycle; busy=0 in the same cycle.
  - q never wraps below 0000.
- hold=1 in RUN freezes q, keeps busy=1 and forces ena=0.
- load and start in the same cycle: load wins and start is dropped.

## Timing
- Start sampled at edge E0: busy=1 after E0.
- First decrement happens at E1 if hold=0.
- For a preset of integer value n with no hold, q=0 and done=1 after edge E_n; busy=1 for exactly n cycles.
- Each hold cycle extends the run by one cycle.
- done is a registered one-cycle pulse; it is never asserted after load or reset.
- Reset mid-run: outputs reach their reset values asynchronously, and no done pulse is produced.
- Latency from load to q updated: 1 edge.

## Structure
- Shared package bcd_pkg holds:
  - BCD_MAX = 4'd9
  - state enum {IDLE, RUN}
  - clamp function (nibble >9 -> 9)
- The up counter uses the same package.
- Sub-module bcd_digit_down, instantiated N_DIGITS times:
  - Inputs: clk, reset, ld, ld_digit, en.
  - Outputs: digit[3:0] and is_zero.
  - Borrow chain is the AND of the lower digits' is_zero.
- The top level holds the FSM, done register and ena logic.

## Test plan
1. load 0x0003, start, hold=0 -> q 0x0003, 0x0002, 0x0001, 0x0000 on successive edges; busy high 3 cycles; done=1 exactly in the cycle q=0x0000.
2. load 0x1000, start -> ena=3'b111 in the first RUN cycle; next q=0x0999; following cycle ena=3'b000 and q=0x0998.
3. load 0x0010, start, hold=1 for 2 cycles after the first decrement -> q holds 0x0009 and ena=0 during hold; run completes 2 cycles late with one done pulse.
4. load 0x0500, start, then load 0x0042 mid-run -> q=0x0042, busy=0, no done; start again counts down from 0x0042.
5. load 0x00AF -> q=0x0099; start with q=0x0000 -> busy stays 0, no done.
6. Assert reset asynchronously mid-run at q=0x0123 -> q=0x0000, busy=0, done=0 before the next edge; no done pulse afterwards.
